// File: rtl/knn_match_if.sv
// Classify handshake, known-image memory and distance-accumulator signals of knn_match_ctrl.
// The skip_cnt member exists only when KNN_EARLY_EXIT_EN is defined.
interface knn_match_if #(
  parameter int LABEL_W = 4,
  parameter int DIST_W  = 32,
  parameter int IDX_W   = 8
);
  logic               start;
  logic [2:0]         state;
  logic [IDX_W-1:0]   known_idx;
  logic [LABEL_W-1:0] known_label;
  logic [DIST_W-1:0]  distance;
  logic               busy;
  logic               done;
  logic [LABEL_W-1:0] best_label;
  logic [IDX_W-1:0]   best_idx;
  logic [DIST_W-1:0]  best_distance;
`ifdef KNN_EARLY_EXIT_EN
  logic [IDX_W-1:0]   skip_cnt;
`endif

  modport master (
    input  start, known_label, distance,
    output state, known_idx, busy, done, best_label, best_idx, best_distance
`ifdef KNN_EARLY_EXIT_EN
    , output skip_cnt
`endif
  );

  modport slave (
    output start, known_label, distance,
    input  state, known_idx, busy, done, best_label, best_idx, best_distance
`ifdef KNN_EARLY_EXIT_EN
    , input skip_cnt
`endif
  );
endinterface

// File: rtl/knn_match_ctrl.sv
// Nearest-neighbour controller: walks every known image, sequences the distance accumulator and
// keeps the minimum distance with its label/index. KNN_EARLY_EXIT_EN aborts hopeless images early.
module knn_match_ctrl #(
  parameter int PIXELS    = 784,
  parameter int NUM_KNOWN = 10,
  parameter int LABEL_W   = 4,
  parameter int DIST_W    = 32,
  parameter int IDX_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  knn_match_if.master bus
);
  localparam int CNT_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  localparam logic [2:0] ST_KNOWN    = 3'b001;
  localparam logic [2:0] ST_INC_DIFF = 3'b011;
  localparam logic [2:0] ST_WRITE    = 3'b101;
  localparam logic [2:0] ST_RST_DIST = 3'b110;

  typedef enum logic [2:0] {IDLE, LOAD, ACCUM, COMPARE, CLEAR, DONE} fsm_t;

  fsm_t               fsm, fsm_nxt;
  logic [2:0]         state_code;
  logic [CNT_W-1:0]   pix_cnt;
  logic [IDX_W-1:0]   known_idx;
  logic               have_best;
  logic               abort;
  logic [LABEL_W-1:0] best_label;
  logic [IDX_W-1:0]   best_idx;
  logic [DIST_W-1:0]  best_distance;
`ifdef KNN_EARLY_EXIT_EN
  logic [IDX_W-1:0]   skip_cnt;
`endif

  always_comb begin
    fsm_nxt    = fsm;
    state_code = ST_RST_DIST;
    abort      = 1'b0;
    case (fsm)
      IDLE: if (bus.start) fsm_nxt = LOAD;
      LOAD: begin
        state_code = ST_KNOWN;
        fsm_nxt    = ACCUM;
      end
      ACCUM: begin
        state_code = ST_INC_DIFF;
        if (pix_cnt == CNT_W'(PIXELS - 1)) fsm_nxt = COMPARE;
`ifdef KNN_EARLY_EXIT_EN
        // Distance only grows, so once it reaches the best so far this image cannot win.
        if (have_best && (bus.distance >= best_distance)) begin
          abort   = 1'b1;
          fsm_nxt = CLEAR;
        end
`endif
      end
      COMPARE: begin
        state_code = ST_WRITE;
        fsm_nxt    = CLEAR;
      end
      CLEAR: fsm_nxt = (known_idx == IDX_W'(NUM_KNOWN - 1)) ? DONE : LOAD;
      DONE:  fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm           <= IDLE;
      pix_cnt       <= '0;
      known_idx     <= '0;
      have_best     <= 1'b0;
      best_label    <= '0;
      best_idx      <= '0;
      best_distance <= '1;
`ifdef KNN_EARLY_EXIT_EN
      skip_cnt      <= '0;
`endif
    end else begin
      fsm <= fsm_nxt;
      case (fsm)
        IDLE: if (bus.start) begin
          known_idx     <= '0;
          have_best     <= 1'b0;
          best_distance <= '1;
`ifdef KNN_EARLY_EXIT_EN
          skip_cnt      <= '0;
`endif
        end
        LOAD:  pix_cnt <= '0;
        ACCUM: begin
          pix_cnt <= pix_cnt + 1'b1;
`ifdef KNN_EARLY_EXIT_EN
          if (abort) skip_cnt <= skip_cnt + 1'b1;
`endif
        end
        COMPARE: begin
          // Strict less-than: on a tie the earlier (lower) index is kept.
          if (!have_best || (bus.distance < best_distance)) begin
            best_distance <= bus.distance;
            best_label    <= bus.known_label;
            best_idx      <= known_idx;
          end
          have_best <= 1'b1;
        end
        CLEAR: if (known_idx != IDX_W'(NUM_KNOWN - 1)) known_idx <= known_idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.state         = state_code;
  assign bus.known_idx     = known_idx;
  assign bus.busy          = (fsm != IDLE);
  assign bus.done          = (fsm == DONE);
  assign bus.best_label    = best_label;
  assign bus.best_idx      = best_idx;
  assign bus.best_distance = best_distance;
`ifdef KNN_EARLY_EXIT_EN
  assign bus.skip_cnt      = skip_cnt;
`endif
endmodule

// File: doc/knn_match_ctrl.md
Name: knn_match_ctrl

Overview:
- Sequencing controller and nearest-neighbour selector that drives the squared-distance accumulator through its 3-bit state bus.
- Per classification it walks every stored known image and issues the per-pixel accumulate cycles.
- It reads back each finished distance and keeps the minimum distance together with its label and index.
- Sits between the top-level classify handshake, the known-image memory (address out, label in) and the distance accumulator.

Parameters:
PIXELS, 784, pixels per image; accumulate cycles per known image
NUM_KNOWN, 10, number of stored known images (>=1)
LABEL_W, 4, width of class label
DIST_W, 32, width of distance bus
IDX_W, 8, width of known-image index; must satisfy 2**IDX_W >= NUM_KNOWN

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin classification; sampled only in IDLE
state  out  3  accumulator command: 000 RESET, 001 KNOWN, 010 KNOWN_INC_DIFF, 011 INC_DIFF, 100 UNKNOWN, 101 WRITE, 110 RESET_DISTANCE
known_idx  out  IDX_W  address of the current known image (pixels and label)
known_label  in  LABEL_W  label of known_idx; 1-cycle read latency
distance  in  DIST_W  running accumulator output
busy  out  1  high from the cycle after start is accepted through the DONE cycle
done  out  1  one-cycle pulse; result valid
best_label  out  LABEL_W  label of the nearest known image
best_idx  out  IDX_W  index of the nearest known image
best_distance  out  DIST_W  minimum squared distance

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous, active-low.
- Reset values: FSM=IDLE, state=110, known_idx=0, busy=0, done=0, best_label=0, best_idx=0, best_distance=all ones.
- FSM states and the state code driven in each:
  - IDLE (110): on start=1 → LOAD; clear known_idx, clear the first flag, set best_distance to all ones.
  - LOAD (001), 1 cycle: memory fetch slot → ACCUM; clear the pixel counter.
  - ACCUM (011), exactly PIXELS cycles: the pixel counter runs 0..PIXELS-1; after count PIXELS-1 → COMPARE.
  - COMPARE (101), 1 cycle: distance is final here, since the accumulator updated on the edge ending the last ACCUM cycle. known_label is valid.
    - Update condition: first image, or distance < best_distance (strict).
    - On update, load best_distance/best_label/best_idx from distance/known_label/known_idx.
    - Then → CLEAR.
  - CLEAR (110), 1 cycle: accumulator clears. If known_idx==NUM_KNOWN-1 → DONE; else known_idx+1 and → LOAD.
  - DONE (110): done=1 for one cycle → IDLE.
- Timing:
  - Cost per known image: PIXELS+3 cycles.
  - Latency from the start-accepting edge to the done cycle: NUM_KNOWN*(PIXELS+3)+1 cycles.
- Tie rule: equal distances do not update, so the lowest index wins.
- best_* hold their value after done until the next start is accepted.
- start while busy: ignored, no queueing. start held high in IDLE after DONE re-triggers a new run.
- known_idx is stable from LOAD through CLEAR of each image. It never exceeds NUM_KNOWN-1 and does not wrap.
- Reset asserted mid-run:
  - All outputs return to their reset values immediately; no done pulse.
  - state=110, so the accumulator clears on its own reset regardless.
- Width: comparison is unsigned DIST_W; the maximum real distance is PIXELS*255^2 = 50,979,600, which fits in 26 bits.

Optional Feature:
- Macro: KNN_EARLY_EXIT_EN
- Defined:
  - In ACCUM, when the first image is already recorded and distance >= best_distance, leave ACCUM next cycle directly to CLEAR, skipping COMPARE. This is valid because distance is monotonic non-decreasing.
  - Adds output skip_cnt, IDX_W bits: number of images aborted this run, cleared at start.
- Undefined: every image runs the full PIXELS cycles; no skip_cnt port.

Test Plan:
- Reset check, with reset low mid-ACCUM → next sample: state=110, busy=0, done=0, best_distance=FFFFFFFF, known_idx=0; no done pulse afterwards.
- PIXELS=4, NUM_KNOWN=3, stub distances 50/20/35, labels 7/2/9:
  - done exactly 3*7+1=22 cycles after the start edge.
  - best_distance=20, best_label=2, best_idx=1.
  - state sequence per image: 001, 011×4, 101, 110.
- Tie handling, distances 30/30/40 → best_idx=0, best_label=label[0].
- start pulsed while busy at cycle 5 → ignored; exactly one done pulse; result identical to the first run.
- NUM_KNOWN=1, distance 0 → best_distance=0, done after PIXELS+4 cycles; known_idx stays 0.
- KNN_EARLY_EXIT_EN, distances ramp to 10 on image 0 and exceed 10 at pixel 2 of image 1:
  - Image 1 aborted after 3 ACCUM cycles.
  - skip_cnt=1, best_idx=0.
